// File: rtl/bird_pkg.sv
// Shared types and height limits for the flappy-bird motion controller.
package bird_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RISE     = 3'd1,
    HOVER    = 3'd2,
    FALL     = 3'd3,
    GROUNDED = 3'd4
  } bird_state_t;

  localparam int             HEIGHT_W   = 4;
  localparam logic [HEIGHT_W-1:0] HEIGHT_MAX = 4'd15;
  localparam logic [HEIGHT_W-1:0] HEIGHT_MIN = 4'd0;

endpackage

// File: rtl/tick_gen.sv
// Motion tick generator: one-cycle tick every TICK_DIV clocks while enabled,
// counter parked at zero while disabled.
module tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, cleared by reset or while frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= {CW{1'b0}};
    end else if (!en) begin
      cnt <= {CW{1'b0}};
    end else if (cnt == LAST) begin
      cnt <= {CW{1'b0}};
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en & (cnt == LAST);

endmodule

// File: rtl/bird_motion_ctrl.sv
// Turns flap key presses into timed incr/decr pulses for the bird-height
// counter: rise, hover, then gravity fall with ceiling/floor clamps.
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int TICK_DIV    = 5_000_000,
  parameter int RISE_TICKS  = 3,
  parameter int HOVER_TICKS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flap,
  input  logic [HEIGHT_W-1:0] height,
  output logic                incr,
  output logic                decr,
  output logic                grounded
);

  localparam int             RCW        = $clog2(RISE_TICKS + 1);
  localparam int             HCW        = $clog2(HOVER_TICKS + 1);
  localparam logic [RCW-1:0] RISE_LOAD  = RCW'(RISE_TICKS);
  localparam logic [HCW-1:0] HOVER_LOAD = HCW'(HOVER_TICKS);

  bird_state_t    state, state_n;
  logic [RCW-1:0] rise_cnt, rise_cnt_n;
  logic [HCW-1:0] hover_cnt, hover_cnt_n;
  logic           incr_n, decr_n, grounded_n;
  logic           flap_q;
  logic           flap_rise;
  logic           tick;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // Key history keeps tracking during freeze so a held key never re-triggers.
  always_ff @(posedge clk) begin
    if (reset) begin
      flap_q <= 1'b0;
    end else begin
      flap_q <= flap;
    end
  end

  assign flap_rise = flap & ~flap_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rise_cnt  <= {RCW{1'b0}};
      hover_cnt <= {HCW{1'b0}};
      incr      <= 1'b0;
      decr      <= 1'b0;
      grounded  <= 1'b0;
    end else begin
      state     <= state_n;
      rise_cnt  <= rise_cnt_n;
      hover_cnt <= hover_cnt_n;
      incr      <= incr_n;
      decr      <= decr_n;
      grounded  <= grounded_n;
    end
  end

  // Next-state and pulse decode; a flap edge always beats a coincident tick.
  always_comb begin
    state_n     = state;
    rise_cnt_n  = rise_cnt;
    hover_cnt_n = hover_cnt;
    incr_n      = 1'b0;
    decr_n      = 1'b0;
    if (!en) begin
      state_n     = state;
      rise_cnt_n  = rise_cnt;
      hover_cnt_n = hover_cnt;
    end else begin
      case (state)
        IDLE: begin
          if (flap_rise) begin
            state_n    = RISE;
            rise_cnt_n = RISE_LOAD;
          end else begin
            state_n = IDLE;
          end
        end
        RISE: begin
          if (flap_rise) begin
            rise_cnt_n = RISE_LOAD;
          end else if (tick) begin
            incr_n = (height != HEIGHT_MAX);
            if (rise_cnt == RCW'(1)) begin
              state_n     = HOVER;
              rise_cnt_n  = {RCW{1'b0}};
              hover_cnt_n = HOVER_LOAD;
            end else begin
              rise_cnt_n = rise_cnt - RCW'(1);
            end
          end else begin
            state_n = RISE;
          end
        end
        HOVER: begin
          if (flap_rise) begin
            state_n    = RISE;
            rise_cnt_n = RISE_LOAD;
          end else if (tick) begin
            if (hover_cnt == HCW'(1)) begin
              state_n     = FALL;
              hover_cnt_n = {HCW{1'b0}};
            end else begin
              hover_cnt_n = hover_cnt - HCW'(1);
            end
          end else begin
            state_n = HOVER;
          end
        end
        FALL: begin
          if (flap_rise) begin
            state_n    = RISE;
            rise_cnt_n = RISE_LOAD;
          end else if (tick) begin
            if (height == HEIGHT_MIN) begin
              state_n = GROUNDED;
            end else begin
              decr_n = 1'b1;
            end
          end else begin
            state_n = FALL;
          end
        end
        GROUNDED: begin
          state_n = GROUNDED;
        end
        default: begin
          state_n     = IDLE;
          rise_cnt_n  = {RCW{1'b0}};
          hover_cnt_n = {HCW{1'b0}};
        end
      endcase
    end
    grounded_n = (state_n == GROUNDED);
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl with a height-counter model and a
// scoreboard of expected incr/decr pulses (kind and spacing).
module tb_bird_motion_ctrl;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       flap  = 1'b0;
  logic [3:0] h     = 4'd8;
  logic       incr, decr, grounded;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int last_pulse = 0;

  typedef struct {
    bit is_incr;
    int gap;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  bird_motion_ctrl #(
    .TICK_DIV    (4),
    .RISE_TICKS  (3),
    .HOVER_TICKS (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flap     (flap),
    .height   (h),
    .incr     (incr),
    .decr     (decr),
    .grounded (grounded)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_incr, input int gap);
    exp_t e;
    e.is_incr = is_incr;
    e.gap     = gap;
    q.push_back(e);
  endtask

  // One clock: sample at negedge, score any pulse, advance the height model.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cycle++;
    chk("exclusive", {31'd0, incr & decr}, 32'd0);
    if (incr | decr) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, incr, decr}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {30'd0, incr, decr}, e.is_incr ? 32'd2 : 32'd1);
        if (e.gap != 0) chk("pulse_gap", cycle - last_pulse, e.gap);
      end
      last_pulse = cycle;
      if (incr === 1'b1) h = h + 4'd1;
      else if (decr === 1'b1) h = h - 4'd1;
    end
  endtask

  task automatic wait_q(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) cyc();
    chk("pulse_timeout", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    flap  = 1'b0;
    cyc();
    reset = 1'b0;
    h     = 4'd8;
    q.delete();
    chk("rst_incr", {31'd0, incr}, 32'd0);
    chk("rst_decr", {31'd0, decr}, 32'd0);
    chk("rst_grounded", {31'd0, grounded}, 32'd0);
  endtask

  task automatic flap_pulse();
    flap = 1'b1;
    cyc();
    flap = 1'b0;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("idle_height", h, 32'd8);
    chk("idle_grounded", {31'd0, grounded}, 32'd0);

    // Single flap from 8: rise to 11, hover, fall to 0, then grounded
    do_reset();
    en = 1'b1;
    push(1'b1, 0); push(1'b1, 4); push(1'b1, 4);
    push(1'b0, 12);
    for (int i = 0; i < 10; i++) push(1'b0, 4);
    flap_pulse();
    wait_q(200);
    chk("fall_height", h, 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_grounded", {31'd0, grounded}, 32'd0);
    cyc();
    for (int i = 0; i < 40; i++) begin
      cyc();
      flap = (i % 6) inside {[2:3]};
      chk("grounded_hold", {31'd0, grounded}, 32'd1);
    end
    flap = 1'b0;
    chk("grounded_height", h, 32'd0);

    // Held flap at 14: one incr to 15, ceiling clamp, then gravity resumes
    do_reset();
    en   = 1'b1;
    h    = 4'd14;
    flap = 1'b1;
    push(1'b1, 0); push(1'b0, 20); push(1'b0, 4);
    for (int i = 0; i < 30; i++) cyc();
    flap = 1'b0;
    chk("ceiling_pulses", q.size(), 32'd0);
    chk("ceiling_height", h, 32'd13);

    // Flap coincident with a FALL tick at height 6
    do_reset();
    en = 1'b1;
    push(1'b1, 0); push(1'b1, 4); push(1'b1, 4);
    push(1'b0, 12);
    for (int i = 0; i < 4; i++) push(1'b0, 4);
    flap_pulse();
    wait_q(100);
    chk("coinc_start_height", h, 32'd6);
    cyc(); cyc(); cyc();
    push(1'b1, 8); push(1'b1, 4); push(1'b1, 4);
    flap_pulse();
    wait_q(40);
    chk("coinc_height", h, 32'd9);

    // Freeze after first incr; key held through unfreeze is not a new flap
    do_reset();
    en = 1'b1;
    push(1'b1, 0);
    flap_pulse();
    wait_q(20);
    chk("freeze_start_height", h, 32'd9);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 5) flap = 1'b1;
    end
    chk("freeze_height", h, 32'd9);
    en = 1'b1;
    push(1'b1, 24); push(1'b1, 4);
    wait_q(40);
    chk("unfreeze_height", h, 32'd11);
    flap = 1'b0;

    // Reset in the tick cycle mid-FALL at height 5
    do_reset();
    en = 1'b1;
    push(1'b1, 0); push(1'b1, 4); push(1'b1, 4);
    push(1'b0, 12);
    for (int i = 0; i < 5; i++) push(1'b0, 4);
    flap_pulse();
    wait_q(100);
    chk("midfall_height", h, 32'd5);
    cyc(); cyc(); cyc();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    chk("post_reset_height", h, 32'd8);
    push(1'b1, 0);
    flap_pulse();
    wait_q(20);
    chk("post_reset_flap_height", h, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
- Upstream driver of the bird-height counter in flappy bird.
- Converts the player's flap key into timed incr/decr pulses: a timed rise after each flap, a short hover, then gravity fall.
- Reads the current height back to clamp at ceiling and floor, and raises a grounded flag when the bird hits the floor.
- The incr/decr outputs connect directly to the height counter's incr/decr inputs; that counter's out feeds back into height.

Parameters:
- TICK_DIV, 5_000_000, clk cycles per motion tick; must be >= 4.
- RISE_TICKS, 3, motion ticks of upward movement per accepted flap; must be >= 1.
- HOVER_TICKS, 2, motion ticks with no movement between rise and fall; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  1  game running; low freezes motion
- flap  input  1  player key, already synchronized to clk, level
- height  input  4  current bird height, fed back from the height counter
- incr  output  1  one-cycle pulse: raise height by 1
- decr  output  1  one-cycle pulse: lower height by 1
- grounded  output  1  level; bird has hit the floor

Behaviour:
- Design: one clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - incr=0, decr=0, grounded=0.
  - State=IDLE, tick counter=0, rise/hover counters=0, flap_q=0.
- Reset mid-operation: the cycle after reset is sampled high, the block is fully in the reset state. No pulse is emitted in that cycle.
- Flap edge detection:
  - flap_q is flap delayed by 1 cycle.
  - flap_rise = flap & ~flap_q.
  - Holding flap high yields exactly one flap_rise.
- Tick generator:
  - While en=1, the counter counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle the counter equals TICK_DIV-1.
  - While en=0, the counter is held at 0.
- Freeze (en=0):
  - FSM and rise/hover counters hold.
  - flap_rise is ignored.
  - incr=decr=0.
  - flap_q still tracks flap, so a key held through unfreeze does not count as a new flap.
- Output timing:
  - incr/decr are asserted in the cycle after the tick that causes them, for exactly 1 cycle.
  - incr and decr are never both 1.
- FSM states: IDLE, RISE, HOVER, FALL, GROUNDED. Transitions are evaluated only when en=1.
  - IDLE:
    - No pulses.
    - flap_rise -> RISE, rise_cnt=RISE_TICKS.
  - RISE:
    - On tick, incr is pulsed if height != 15; otherwise no pulse (ceiling clamp, no wrap).
    - On tick, rise_cnt decrements; if it reaches 0 -> HOVER, hover_cnt=HOVER_TICKS.
    - flap_rise reloads rise_cnt=RISE_TICKS and the state stays RISE.
  - HOVER:
    - No pulses.
    - On tick, hover_cnt decrements; if it reaches 0 -> FALL.
    - flap_rise -> RISE with reload.
  - FALL:
    - On tick with height != 0, decr is pulsed.
    - On tick with height == 0, go to GROUNDED with no pulse (floor clamp, no wrap).
    - flap_rise -> RISE with reload.
  - GROUNDED:
    - grounded=1 from the cycle after entry.
    - No pulses; flap is ignored.
    - Exit only by reset.
- Simultaneous events:
  - flap_rise and tick in the same cycle, in RISE/HOVER/FALL: flap_rise wins. No pulse is emitted for that tick, the state becomes RISE, and rise_cnt=RISE_TICKS.
  - flap_rise and tick in the same cycle, in IDLE: enter RISE. That tick is not counted.
- Height sampling: height is sampled in the tick cycle. With TICK_DIV >= 4, the counter has updated from the previous pulse before the next tick.

Decomposition:
- Package bird_pkg holds:
  - typedef enum logic [2:0] bird_state_t {IDLE, RISE, HOVER, FALL, GROUNDED};
  - HEIGHT_W=4, HEIGHT_MAX=4'd15, HEIGHT_MIN=4'd0.
- One sub-module, tick_gen, parameterized by TICK_DIV:
  - Inputs: clk, reset, en.
  - Output: tick.
  - Counter width is $clog2(TICK_DIV).
- The FSM, edge detection and clamps stay in bird_motion_ctrl.

Test Plan:
- Bench setup: TICK_DIV=4, RISE_TICKS=3, HOVER_TICKS=2. The bench models the height counter: reset value 8, +1 on incr, -1 on decr.
- Reset and idle: reset 1 cycle, then 20 cycles with en=1 and flap=0 -> incr, decr and grounded stay 0, height stays 8.
- Single flap from height 8 -> 3 incr pulses 4 cycles apart, height reaches 11. Then 2 ticks with no pulse. Then 11 decr pulses 4 cycles apart, height reaches 0. On the next tick, grounded=1 and stays 1 for 40 further cycles.
- Held flap and ceiling: flap held high for 30 cycles starting at height 14 -> exactly one incr (height 15), no further incr, height never wraps to 0.
- Flap coincident with a FALL tick at height 6 -> no decr that tick. Then 3 incr pulses on the following ticks, height 6->9.
- Freeze: en=0 for 20 cycles after the first incr of a rise (height 9) -> no pulses and no state change. After en=1, exactly 2 more incr pulses, height 11.
- Reset mid-FALL at height 5 -> the next cycle has incr=decr=grounded=0 and state IDLE. No pulses follow until a new flap.
